// File: rtl/mem_arb.sv
// Two-requester arbiter in front of a shared single-port synchronous RAM.
// A (load/store) has priority, and B (fetch) has bounded wait. Optional counters: MEM_ARB_STATS_EN.
module mem_arb #(
  // Defaults match HBIT_ADDR/HBIT_DATA of the project sizes header (4096 x 16-bit words)
  parameter int unsigned HBIT_ADDR  = 11,
  parameter int unsigned HBIT_DATA  = 15,
  parameter int unsigned STARVE_MAX = 3,
  parameter int unsigned W_STAT     = 16
) (
  input  logic                iw_clk,
  input  logic                iw_rst,

  input  logic                iw_a_req,
  input  logic                iw_a_we,
  input  logic [HBIT_ADDR:0]  iw_a_addr,
  input  logic [HBIT_DATA:0]  iw_a_wdata,
  output logic                ow_a_gnt,
  output logic                or_a_ack,
  output logic [HBIT_DATA:0]  ow_a_rdata,

  input  logic                iw_b_req,
  input  logic                iw_b_we,
  input  logic [HBIT_ADDR:0]  iw_b_addr,
  input  logic [HBIT_DATA:0]  iw_b_wdata,
  output logic                ow_b_gnt,
  output logic                or_b_ack,
  output logic [HBIT_DATA:0]  ow_b_rdata,

  output logic                ow_mem_we,
  output logic [HBIT_ADDR:0]  ow_mem_addr,
  output logic [HBIT_DATA:0]  ow_mem_wdata,
  input  logic [HBIT_DATA:0]  iw_mem_rdata,

  input  logic                iw_stat_clr,
  output logic [W_STAT-1:0]   or_a_cnt,
  output logic [W_STAT-1:0]   or_b_cnt,
  output logic [W_STAT-1:0]   or_conf_cnt
);

  localparam logic [3:0] LP_STARVE_MAX = 4'(STARVE_MAX);

  logic [3:0] r_starve;
  logic       w_force_b;
  logic       w_a_gnt;
  logic       w_b_gnt;

  // B wins outright once it has been passed over STARVE_MAX times in a row
  assign w_force_b = iw_b_req && (r_starve == LP_STARVE_MAX);
  assign w_a_gnt   = !iw_rst && iw_a_req && !w_force_b;
  assign w_b_gnt   = !iw_rst && iw_b_req && (w_force_b || !iw_a_req);

  assign ow_a_gnt = w_a_gnt;
  assign ow_b_gnt = w_b_gnt;

  // With no grant the address falls back to A's: a harmless read with no ack
  always_comb begin
    ow_mem_we    = 1'b0;
    ow_mem_addr  = iw_a_addr;
    ow_mem_wdata = iw_a_wdata;
    if (w_a_gnt) begin
      ow_mem_we = iw_a_we;
    end else if (w_b_gnt) begin
      ow_mem_we    = iw_b_we;
      ow_mem_addr  = iw_b_addr;
      ow_mem_wdata = iw_b_wdata;
    end
  end

  // RAM read data is already registered, so it lines up with the acks
  assign ow_a_rdata = iw_mem_rdata;
  assign ow_b_rdata = iw_mem_rdata;

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      or_a_ack <= 1'b0;
      or_b_ack <= 1'b0;
      r_starve <= 4'd0;
    end else begin
      or_a_ack <= w_a_gnt;
      or_b_ack <= w_b_gnt;
      if (!iw_b_req || w_b_gnt) begin
        r_starve <= 4'd0;
      end else if (w_a_gnt && (r_starve < LP_STARVE_MAX)) begin
        r_starve <= r_starve + 4'd1;
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  localparam logic [W_STAT-1:0] LP_STAT_MAX = '1;

  logic [W_STAT-1:0] r_a_cnt;
  logic [W_STAT-1:0] r_b_cnt;
  logic [W_STAT-1:0] r_conf_cnt;
  logic              w_conf;

  assign w_conf = iw_a_req && iw_b_req;

  // Clear has priority over a same-cycle increment; all counters saturate
  always_ff @(posedge iw_clk) begin
    if (iw_rst || iw_stat_clr) begin
      r_a_cnt    <= '0;
      r_b_cnt    <= '0;
      r_conf_cnt <= '0;
    end else begin
      if (w_a_gnt && (r_a_cnt != LP_STAT_MAX)) begin
        r_a_cnt <= r_a_cnt + 1'b1;
      end
      if (w_b_gnt && (r_b_cnt != LP_STAT_MAX)) begin
        r_b_cnt <= r_b_cnt + 1'b1;
      end
      if (w_conf && (r_conf_cnt != LP_STAT_MAX)) begin
        r_conf_cnt <= r_conf_cnt + 1'b1;
      end
    end
  end

  assign or_a_cnt    = r_a_cnt;
  assign or_b_cnt    = r_b_cnt;
  assign or_conf_cnt = r_conf_cnt;
`else
  logic w_unused_stat_clr;

  assign w_unused_stat_clr = iw_stat_clr;
  assign or_a_cnt          = '0;
  assign or_b_cnt          = '0;
  assign or_conf_cnt       = '0;
`endif

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a behavioural 4096x16 synchronous RAM (read-before-write).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [11:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_gnt, a_ack, b_gnt, b_ack;
  logic [15:0] a_rdata, b_rdata;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        stat_clr;
  logic [15:0] a_cnt, b_cnt, conf_cnt;

  int n_vec  = 0;
  int n_fail = 0;

  logic [15:0] mem [0:4095];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  mem_arb #(
    .HBIT_ADDR  (11),
    .HBIT_DATA  (15),
    .STARVE_MAX (3),
    .W_STAT     (16)
  ) dut (
    .iw_clk       (clk),
    .iw_rst       (rst),
    .iw_a_req     (a_req),
    .iw_a_we      (a_we),
    .iw_a_addr    (a_addr),
    .iw_a_wdata   (a_wdata),
    .ow_a_gnt     (a_gnt),
    .or_a_ack     (a_ack),
    .ow_a_rdata   (a_rdata),
    .iw_b_req     (b_req),
    .iw_b_we      (b_we),
    .iw_b_addr    (b_addr),
    .iw_b_wdata   (b_wdata),
    .ow_b_gnt     (b_gnt),
    .or_b_ack     (b_ack),
    .ow_b_rdata   (b_rdata),
    .ow_mem_we    (mem_we),
    .ow_mem_addr  (mem_addr),
    .ow_mem_wdata (mem_wdata),
    .iw_mem_rdata (mem_rdata),
    .iw_stat_clr  (stat_clr),
    .or_a_cnt     (a_cnt),
    .or_b_cnt     (b_cnt),
    .or_conf_cnt  (conf_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic req, input logic we, input logic [11:0] addr,
                         input logic [15:0] wd);
    a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
  endtask

  task automatic drive_b(input logic req, input logic we, input logic [11:0] addr,
                         input logic [15:0] wd);
    b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
  endtask

  task automatic chk_stats(input string tag, input logic [15:0] ea, input logic [15:0] eb,
                           input logic [15:0] ec);
`ifdef MEM_ARB_STATS_EN
    chk({tag, "_a_cnt"}, 32'(a_cnt), 32'(ea));
    chk({tag, "_b_cnt"}, 32'(b_cnt), 32'(eb));
    chk({tag, "_conf_cnt"}, 32'(conf_cnt), 32'(ec));
`else
    chk({tag, "_a_cnt_off"}, 32'(a_cnt), 32'(ea & 16'h0));
    chk({tag, "_b_cnt_off"}, 32'(b_cnt), 32'(eb & 16'h0));
    chk({tag, "_conf_cnt_off"}, 32'(conf_cnt), 32'(ec & 16'h0));
`endif
  endtask

  initial begin
    rst = 1'b1; stat_clr = 1'b0;
    drive_a(1'b0, 1'b0, 12'h000, 16'h0000);
    drive_b(1'b0, 1'b0, 12'h000, 16'h0000);

    // Reset state
    @(negedge clk); #1;
    chk("rst_a_ack", 32'(a_ack), 0);
    chk("rst_b_ack", 32'(b_ack), 0);
    chk("rst_starve", 32'(dut.r_starve), 0);
    chk_stats("rst", 16'd0, 16'd0, 16'd0);

    // A writes 0x010 = 0xA5A5 (preload through the arbiter)
    @(negedge clk); rst = 1'b0;
    drive_a(1'b1, 1'b1, 12'h010, 16'hA5A5); #1;
    chk("wr_a_gnt", 32'(a_gnt), 1);
    chk("wr_b_gnt", 32'(b_gnt), 0);
    chk("wr_mem_we", 32'(mem_we), 1);
    chk("wr_mem_addr", 32'(mem_addr), 32'h010);
    chk("wr_mem_wdata", 32'(mem_wdata), 32'hA5A5);

    // A reads 0x010 alone
    @(negedge clk); drive_a(1'b1, 1'b0, 12'h010, 16'h0000); #1;
    chk("rd_a_gnt", 32'(a_gnt), 1);
    chk("rd_mem_we", 32'(mem_we), 0);
    chk("wr_a_ack", 32'(a_ack), 1);

    @(negedge clk); drive_a(1'b0, 1'b0, 12'h010, 16'h0000); #1;
    chk("rd_a_ack", 32'(a_ack), 1);
    chk("rd_a_rdata", 32'(a_rdata), 32'hA5A5);
    chk("rd_b_ack", 32'(b_ack), 0);
    chk("idle_a_gnt", 32'(a_gnt), 0);

    // B writes 0x0FF = 0x1234, then reads it back
    @(negedge clk); drive_b(1'b1, 1'b1, 12'h0FF, 16'h1234); #1;
    chk("bwr_b_gnt", 32'(b_gnt), 1);
    chk("bwr_a_gnt", 32'(a_gnt), 0);
    chk("bwr_mem_addr", 32'(mem_addr), 32'h0FF);
    chk("bwr_mem_we", 32'(mem_we), 1);
    chk("bwr_a_ack", 32'(a_ack), 0);

    @(negedge clk); drive_b(1'b1, 1'b0, 12'h0FF, 16'h0000); #1;
    chk("brd_b_gnt", 32'(b_gnt), 1);
    chk("bwr_b_ack", 32'(b_ack), 1);

    // Idle: address falls back to A's, no write
    @(negedge clk);
    drive_b(1'b0, 1'b0, 12'h0FF, 16'h0000);
    drive_a(1'b0, 1'b1, 12'h123, 16'hDEAD); #1;
    chk("brd_b_ack", 32'(b_ack), 1);
    chk("brd_b_rdata", 32'(b_rdata), 32'h1234);
    chk("idle_mem_addr", 32'(mem_addr), 32'h123);
    chk("idle_mem_we", 32'(mem_we), 0);

    // Simultaneous single requests
    @(negedge clk);
    drive_a(1'b1, 1'b0, 12'h010, 16'h0000);
    drive_b(1'b1, 1'b0, 12'h0FF, 16'h0000); #1;
    chk("sim_a_gnt", 32'(a_gnt), 1);
    chk("sim_b_gnt", 32'(b_gnt), 0);
    chk("sim_mem_addr", 32'(mem_addr), 32'h010);
    chk("sim_starve0", 32'(dut.r_starve), 0);

    @(negedge clk); drive_a(1'b0, 1'b0, 12'h010, 16'h0000); #1;
    chk("sim_b_gnt2", 32'(b_gnt), 1);
    chk("sim_mem_addr2", 32'(mem_addr), 32'h0FF);
    chk("sim_a_ack", 32'(a_ack), 1);
    chk("sim_a_rdata", 32'(a_rdata), 32'hA5A5);
    chk("sim_starve1", 32'(dut.r_starve), 1);

    @(negedge clk); drive_b(1'b0, 1'b0, 12'h0FF, 16'h0000); stat_clr = 1'b1; #1;
    chk("sim_b_ack", 32'(b_ack), 1);
    chk("sim_b_rdata", 32'(b_rdata), 32'h1234);
    chk("sim_a_ack2", 32'(a_ack), 0);

    // Contention: both request continuously for 8 cycles -> A,A,A,B,A,A,A,B
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      stat_clr = 1'b0;
      drive_a(1'b1, 1'b0, 12'h010, 16'h0000);
      drive_b(1'b1, 1'b0, 12'h0FF, 16'h0000); #1;
      chk("cont_a_gnt", 32'((i % 4) != 3), 32'(a_gnt) ^ 32'd0 ? 32'(a_gnt) : 32'(a_gnt));
      chk("cont_b_gnt", 32'(b_gnt), 32'((i % 4) == 3));
      chk("cont_starve", 32'(dut.r_starve), 32'(i % 4));
      chk("cont_a_ack", 32'(a_ack), 32'((i > 0) && ((i % 4) != 0)));
      chk("cont_b_ack", 32'(b_ack), 32'((i > 0) && ((i % 4) == 0)));
      if (i == 4) chk("cont_b_rdata", 32'(b_rdata), 32'h1234);
    end

    @(negedge clk);
    drive_a(1'b0, 1'b0, 12'h010, 16'h0000);
    drive_b(1'b0, 1'b0, 12'h0FF, 16'h0000);
    stat_clr = 1'b1; #1;
    chk("cont_b_ack_last", 32'(b_ack), 1);
    chk("cont_starve_end", 32'(dut.r_starve), 0);
    chk_stats("cont", 16'd6, 16'd2, 16'd8);

    @(negedge clk); stat_clr = 1'b0; #1;
    chk_stats("clr", 16'd0, 16'd0, 16'd0);

    // Reset mid-operation: A requests while reset is high
    @(negedge clk); rst = 1'b1;
    drive_a(1'b1, 1'b0, 12'h010, 16'h0000);
    drive_b(1'b1, 1'b0, 12'h0FF, 16'h0000); #1;
    chk("rstop_a_gnt", 32'(a_gnt), 0);
    chk("rstop_b_gnt", 32'(b_gnt), 0);

    @(negedge clk); rst = 1'b0; drive_b(1'b0, 1'b0, 12'h0FF, 16'h0000); #1;
    chk("rstop_a_ack", 32'(a_ack), 0);
    chk("rstop_starve", 32'(dut.r_starve), 0);
    chk("post_a_gnt", 32'(a_gnt), 1);
    chk_stats("rstop", 16'd0, 16'd0, 16'd0);

    @(negedge clk); drive_a(1'b0, 1'b0, 12'h010, 16'h0000); #1;
    chk("post_a_ack", 32'(a_ack), 1);
    chk("post_a_rdata", 32'(a_rdata), 32'hA5A5);
    chk("post_b_ack", 32'(b_ack), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
